// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and constants for the framed UART receiver.
// State encoding, error codes and the default start-of-frame byte.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_SEND
    } state_t;

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEF_HEADER  = 8'hAA;

    // Running checksum step: plain 8-bit wrap-around add.
    function automatic logic [7:0] chk_add(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_frame_if.sv
// uart_frame_if: byte-strobe input, payload stream output and status.
// master drives bytes and out_ready; slave is the frame receiver.
interface uart_frame_if;

    logic       rx_data_valid;
    logic [7:0] rx_data_in;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic [7:0] frame_len;
    logic       err_valid;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_data_valid,
        output rx_data_in,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  frame_len,
        input  err_valid,
        input  err_code,
        input  busy
    );

    modport slave (
        input  rx_data_valid,
        input  rx_data_in,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last,
        output frame_len,
        output err_valid,
        output err_code,
        output busy
    );

endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: MAX_LEN x 8 payload store.
// One synchronous write port, one asynchronous read port.
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [MAX_LEN];

    // Write the addressed entry; address decode keeps index widths exact.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (we_i && (waddr_i == AW'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    // Combinational read mux; out-of-range addresses read as zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (raddr_i == AW'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses HEADER/LEN/payload/CHK frames from byte strobes.
// Releases checksum-verified payloads as a valid/ready stream with last.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] HEADER      = DEF_HEADER,
    parameter int         TIMEOUT_CYC = 15000
) (
    input  logic        clk,
    input  logic        rst,
    uart_frame_if.slave bus
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_SAT  = TW'(TIMEOUT_CYC);

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_v_q, err_v_d;
    logic [1:0]    err_c_q, err_c_d;

    logic          rx_v;
    logic [7:0]    rx_b;
    logic          we;
    logic [7:0]    rdata;
    logic          last;
    logic          in_frame;
    logic          sending;
    logic [IW-1:0] idx_nx;

    assign rx_v     = bus.rx_data_valid;
    assign rx_b     = bus.rx_data_in;
    assign sending  = (state_q == ST_SEND);
    assign in_frame = (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) ||
                      (state_q == ST_CHK);
    assign idx_nx   = idx_q + IW'(1);
    assign last     = (8'(rd_q) == (len_q - 8'd1));

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (IW)
    ) u_buf (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (idx_q),
        .wdata_i (rx_b),
        .raddr_i (rd_q),
        .rdata_o (rdata)
    );

    // State, counters, checksum and error status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            tmo_q   <= '0;
            err_v_q <= 1'b0;
            err_c_q <= ERR_OVERRUN;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            err_v_q <= err_v_d;
            err_c_q <= err_c_d;
        end
    end

    // Frame parser, inter-byte timeout and output stream sequencing.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        tmo_d   = '0;
        err_v_d = 1'b0;
        err_c_d = err_c_q;
        we      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                rd_d  = '0;
                if (rx_v && (rx_b == HEADER)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_v) begin
                    if ((rx_b == 8'd0) || (rx_b > LEN_MAX)) begin
                        err_v_d = 1'b1;
                        err_c_d = ERR_LEN;
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = rx_b;
                        sum_d   = rx_b;
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_v) begin
                    we    = 1'b1;
                    sum_d = chk_add(sum_q, rx_b);
                    idx_d = idx_nx;
                    if (8'(idx_nx) == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_v) begin
                    if (rx_b == sum_q) begin
                        rd_d    = '0;
                        state_d = ST_SEND;
                    end else begin
                        err_v_d = 1'b1;
                        err_c_d = ERR_CHK;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SEND: begin
                // Bytes arriving while the buffer drains are dropped.
                if (rx_v) begin
                    err_v_d = 1'b1;
                    err_c_d = ERR_OVERRUN;
                end
                if (bus.out_ready) begin
                    rd_d = rd_q + IW'(1);
                    if (last) begin
                        rd_d    = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Silence inside a frame: count, and abandon once the limit is hit.
        if (in_frame && !rx_v) begin
            if (tmo_q == TMO_LAST) begin
                err_v_d = 1'b1;
                err_c_d = ERR_TIMEOUT;
                state_d = ST_IDLE;
            end else if (tmo_q == TMO_SAT) begin
                tmo_d = tmo_q;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign bus.out_valid = sending;
    assign bus.out_data  = sending ? rdata : 8'd0;
    assign bus.out_last  = sending && last;
    assign bus.frame_len = len_q;
    assign bus.err_valid = err_v_q;
    assign bus.err_code  = err_c_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
